// File: rtl/lpa_tile_scheduler.sv
// Job sequencer for the linear processing array: splits one matmul descriptor into
// batch-tile-major tile commands, retires tiles from the result stream, and handles abort.
module lpa_tile_scheduler #(
  parameter int DIM_WIDTH       = 16,
  parameter int ID_WIDTH        = 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int RST_CYCLES      = 4,
  localparam int OW             = $clog2(MAX_OUTSTANDING + 1),
  localparam int RCW            = $clog2(RST_CYCLES + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_cfg_valid,
  output logic                 s_cfg_ready,
  input  logic [DIM_WIDTH-1:0] s_cfg_len,
  input  logic [DIM_WIDTH-1:0] s_cfg_out_tiles,
  input  logic [DIM_WIDTH-1:0] s_cfg_batch_tiles,
  output logic                 m_cmd_valid,
  input  logic                 m_cmd_ready,
  output logic [DIM_WIDTH-1:0] m_cmd_out_tile,
  output logic [DIM_WIDTH-1:0] m_cmd_batch_tile,
  output logic [DIM_WIDTH-1:0] m_cmd_len,
  output logic [ID_WIDTH-1:0]  m_cmd_id,
  input  logic                 snoop_tvalid,
  input  logic                 snoop_tready,
  input  logic                 snoop_tlast,
  input  logic                 err_unalligned_data,
  output logic                 lpa_rst,
  output logic                 busy,
  output logic                 done,
  output logic                 err_cfg,
  output logic                 err_abort,
  output logic [OW-1:0]        outstanding
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, ABORT} state_t;

  localparam logic [OW-1:0]        MAX_O    = OW'(MAX_OUTSTANDING);
  localparam logic [RCW-1:0]       RST_LAST = RCW'(RST_CYCLES - 1);
  localparam logic [DIM_WIDTH-1:0] DIM_ONE  = DIM_WIDTH'(1);
  localparam logic [ID_WIDTH-1:0]  ID_ONE   = ID_WIDTH'(1);
  localparam logic [OW-1:0]        OUT_ONE  = OW'(1);

  state_t               state_q, state_d;
  logic [DIM_WIDTH-1:0] len_q, len_d;
  logic [DIM_WIDTH-1:0] nt_q, nt_d;
  logic [DIM_WIDTH-1:0] mt_q, mt_d;
  logic [DIM_WIDTH-1:0] out_idx_q, out_idx_d;
  logic [DIM_WIDTH-1:0] batch_idx_q, batch_idx_d;
  logic [ID_WIDTH-1:0]  id_q, id_d;
  logic [OW-1:0]        outstanding_q, outstanding_d;
  logic [RCW-1:0]       rst_cnt_q, rst_cnt_d;
  logic                 cfg_ready_q, cfg_ready_d;
  logic                 cmd_valid_q, cmd_valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_cfg_q, err_cfg_d;
  logic                 err_abort_q, err_abort_d;
  logic                 lpa_rst_q, lpa_rst_d;

  logic          cfg_hs;
  logic          cfg_bad;
  logic          cmd_hs;
  logic          retire;
  logic          out_wrap;
  logic          last_tile;
  logic [OW-1:0] outstanding_nx;

  always_comb begin
    cfg_hs    = s_cfg_valid & cfg_ready_q;
    cfg_bad   = (s_cfg_len == '0) | (s_cfg_out_tiles == '0) | (s_cfg_batch_tiles == '0);
    cmd_hs    = cmd_valid_q & m_cmd_ready;
    // Retires with nothing in flight are dropped so the counter cannot underflow.
    retire    = snoop_tvalid & snoop_tready & snoop_tlast & (outstanding_q != '0);
    out_wrap  = (out_idx_q == nt_q - DIM_ONE);
    last_tile = out_wrap & (batch_idx_q == mt_q - DIM_ONE);

    outstanding_nx = outstanding_q;
    if (cmd_hs && !retire) begin
      outstanding_nx = outstanding_q + OUT_ONE;
    end else if (!cmd_hs && retire) begin
      outstanding_nx = outstanding_q - OUT_ONE;
    end
  end

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    nt_d          = nt_q;
    mt_d          = mt_q;
    out_idx_d     = out_idx_q;
    batch_idx_d   = batch_idx_q;
    id_d          = id_q;
    outstanding_d = outstanding_q;
    rst_cnt_d     = rst_cnt_q;
    cfg_ready_d   = cfg_ready_q;
    cmd_valid_d   = cmd_valid_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    err_cfg_d     = 1'b0;
    err_abort_d   = err_abort_q;
    lpa_rst_d     = lpa_rst_q;

    case (state_q)
      IDLE: begin
        if (cfg_hs) begin
          if (cfg_bad) begin
            err_cfg_d = 1'b1;
            done_d    = 1'b1;
          end else begin
            len_d         = s_cfg_len;
            nt_d          = s_cfg_out_tiles;
            mt_d          = s_cfg_batch_tiles;
            out_idx_d     = '0;
            batch_idx_d   = '0;
            id_d          = '0;
            outstanding_d = '0;
            err_abort_d   = 1'b0;
            cfg_ready_d   = 1'b0;
            busy_d        = 1'b1;
            cmd_valid_d   = 1'b1;
            state_d       = ISSUE;
          end
        end
      end

      ISSUE: begin
        if (err_unalligned_data) begin
          state_d       = ABORT;
          cmd_valid_d   = 1'b0;
          outstanding_d = '0;
          err_abort_d   = 1'b1;
          lpa_rst_d     = 1'b1;
          rst_cnt_d     = '0;
        end else begin
          outstanding_d = outstanding_nx;
          // Valid is recomputed from the post-update count so a freed slot is
          // offered on the very next cycle without a bubble.
          cmd_valid_d   = (outstanding_nx < MAX_O);
          if (cmd_hs) begin
            id_d = id_q + ID_ONE;
            if (out_wrap) begin
              out_idx_d   = '0;
              batch_idx_d = batch_idx_q + DIM_ONE;
            end else begin
              out_idx_d = out_idx_q + DIM_ONE;
            end
            if (last_tile) begin
              cmd_valid_d = 1'b0;
              state_d     = DRAIN;
            end
          end
        end
      end

      DRAIN: begin
        if (err_unalligned_data) begin
          state_d       = ABORT;
          cmd_valid_d   = 1'b0;
          outstanding_d = '0;
          err_abort_d   = 1'b1;
          lpa_rst_d     = 1'b1;
          rst_cnt_d     = '0;
        end else begin
          outstanding_d = outstanding_nx;
          if (outstanding_nx == '0) begin
            done_d      = 1'b1;
            busy_d      = 1'b0;
            cfg_ready_d = 1'b1;
            state_d     = IDLE;
          end
        end
      end

      ABORT: begin
        outstanding_d = '0;
        if (rst_cnt_q == RST_LAST) begin
          lpa_rst_d   = 1'b0;
          rst_cnt_d   = '0;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          cfg_ready_d = 1'b1;
          state_d     = IDLE;
        end else begin
          rst_cnt_d = rst_cnt_q + RCW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      len_q         <= '0;
      nt_q          <= '0;
      mt_q          <= '0;
      out_idx_q     <= '0;
      batch_idx_q   <= '0;
      id_q          <= '0;
      outstanding_q <= '0;
      rst_cnt_q     <= '0;
      cfg_ready_q   <= 1'b1;
      cmd_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_cfg_q     <= 1'b0;
      err_abort_q   <= 1'b0;
      lpa_rst_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      nt_q          <= nt_d;
      mt_q          <= mt_d;
      out_idx_q     <= out_idx_d;
      batch_idx_q   <= batch_idx_d;
      id_q          <= id_d;
      outstanding_q <= outstanding_d;
      rst_cnt_q     <= rst_cnt_d;
      cfg_ready_q   <= cfg_ready_d;
      cmd_valid_q   <= cmd_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_cfg_q     <= err_cfg_d;
      err_abort_q   <= err_abort_d;
      lpa_rst_q     <= lpa_rst_d;
    end
  end

  assign s_cfg_ready      = cfg_ready_q;
  assign m_cmd_valid      = cmd_valid_q;
  assign m_cmd_out_tile   = out_idx_q;
  assign m_cmd_batch_tile = batch_idx_q;
  assign m_cmd_len        = len_q;
  assign m_cmd_id         = id_q;
  assign lpa_rst          = lpa_rst_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign err_cfg          = err_cfg_q;
  assign err_abort        = err_abort_q;
  assign outstanding      = outstanding_q;

endmodule

// File: tb/tb_lpa_tile_scheduler.sv
// Directed bench for lpa_tile_scheduler: per-cycle vector table plus multi-cycle sequences.
module tb_lpa_tile_scheduler;

  logic        clk;
  logic        rst_n;
  logic        s_cfg_valid;
  logic        s_cfg_ready;
  logic [15:0] s_cfg_len;
  logic [15:0] s_cfg_out_tiles;
  logic [15:0] s_cfg_batch_tiles;
  logic        m_cmd_valid;
  logic        m_cmd_ready;
  logic [15:0] m_cmd_out_tile;
  logic [15:0] m_cmd_batch_tile;
  logic [15:0] m_cmd_len;
  logic [7:0]  m_cmd_id;
  logic        snoop_tvalid;
  logic        snoop_tready;
  logic        snoop_tlast;
  logic        err_unalligned_data;
  logic        lpa_rst;
  logic        busy;
  logic        done;
  logic        err_cfg;
  logic        err_abort;
  logic [2:0]  outstanding;

  lpa_tile_scheduler #(
    .DIM_WIDTH(16), .ID_WIDTH(8), .MAX_OUTSTANDING(4), .RST_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_cfg_valid(s_cfg_valid), .s_cfg_ready(s_cfg_ready), .s_cfg_len(s_cfg_len),
    .s_cfg_out_tiles(s_cfg_out_tiles), .s_cfg_batch_tiles(s_cfg_batch_tiles),
    .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready), .m_cmd_out_tile(m_cmd_out_tile),
    .m_cmd_batch_tile(m_cmd_batch_tile), .m_cmd_len(m_cmd_len), .m_cmd_id(m_cmd_id),
    .snoop_tvalid(snoop_tvalid), .snoop_tready(snoop_tready), .snoop_tlast(snoop_tlast),
    .err_unalligned_data(err_unalligned_data), .lpa_rst(lpa_rst), .busy(busy), .done(done),
    .err_cfg(err_cfg), .err_abort(err_abort), .outstanding(outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        cv;
    logic [15:0] len, nt, mt;
    logic        rdy;
    logic [2:0]  snp;
    logic        err;
    logic        crdy, val, bsy, dn, ecfg, eab, lrst;
    logic [2:0]  outs;
    logic [15:0] ot, bt;
    logic [7:0]  id;
    logic [15:0] ln;
  } vec_t;

  vec_t tbl[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic vec_t mk(input logic cv, input logic [15:0] len, nt, mt, input logic rdy,
                              input logic [2:0] snp, input logic err,
                              input logic crdy, val, bsy, dn, ecfg, eab, lrst,
                              input logic [2:0] outs, input logic [15:0] ot, bt,
                              input logic [7:0] id, input logic [15:0] ln);
    vec_t v;
    v.cv = cv; v.len = len; v.nt = nt; v.mt = mt; v.rdy = rdy; v.snp = snp; v.err = err;
    v.crdy = crdy; v.val = val; v.bsy = bsy; v.dn = dn; v.ecfg = ecfg; v.eab = eab;
    v.lrst = lrst; v.outs = outs; v.ot = ot; v.bt = bt; v.id = id; v.ln = ln;
    return v;
  endfunction

  // Payload fields only matter while a command is offered, so they are masked otherwise.
  function automatic logic [79:0] pk(input logic crdy, val, bsy, dn, ecfg, eab, lrst,
                                     input logic [2:0] outs, input logic [15:0] ot, bt,
                                     input logic [7:0] id, input logic [15:0] ln);
    return {14'd0, crdy, val, bsy, dn, ecfg, eab, lrst, outs, val ? {ot, bt, id, ln} : 56'd0};
  endfunction

  function automatic logic [79:0] dut_pk();
    return pk(s_cfg_ready, m_cmd_valid, busy, done, err_cfg, err_abort, lpa_rst, outstanding,
              m_cmd_out_tile, m_cmd_batch_tile, m_cmd_id, m_cmd_len);
  endfunction

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  task automatic drive(input vec_t v);
    s_cfg_valid         = v.cv;
    s_cfg_len           = v.len;
    s_cfg_out_tiles     = v.nt;
    s_cfg_batch_tiles   = v.mt;
    m_cmd_ready         = v.rdy;
    snoop_tvalid        = v.snp[2];
    snoop_tready        = v.snp[1];
    snoop_tlast         = v.snp[0];
    err_unalligned_data = v.err;
  endtask

  task automatic set_snoop(input logic s);
    snoop_tvalid = s;
    snoop_tready = s;
    snoop_tlast  = s;
  endtask

  task automatic start_job(input logic [15:0] len, nt, mt);
    s_cfg_valid       = 1'b1;
    s_cfg_len         = len;
    s_cfg_out_tiles   = nt;
    s_cfg_batch_tiles = mt;
    @(negedge clk);
    s_cfg_valid = 1'b0;
  endtask

  initial begin
    int   issue_cnt, retire_cnt, max_out, done_cyc, last_ret_cyc, hs;
    int   retire_at[$];
    logic seen;

    rst_n = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (3) @(negedge clk);
    chk("reset_values", dut_pk(), pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;

    // cv len nt mt rdy snp err | crdy val busy done ecfg eab lrst outs ot bt id ln
    tbl.push_back(mk(0, 0, 0, 0, 0, 3'b000, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 5, 0, 2, 0, 3'b000, 0,  1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3'b000, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8, 2, 1, 0, 3'b000, 0,  0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 8));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3'b000, 0,  0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 8));
    tbl.push_back(mk(0, 0, 0, 0, 1, 3'b000, 0,  0, 1, 1, 0, 0, 0, 0, 1, 1, 0, 1, 8));
    tbl.push_back(mk(0, 0, 0, 0, 1, 3'b111, 0,  0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3'b111, 0,  1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3'b000, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3'b111, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 3, 4, 1, 0, 3'b000, 0,  0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0, 1, 3'b000, 0,  0, 1, 1, 0, 0, 0, 0, 1, 1, 0, 1, 3));
    tbl.push_back(mk(0, 0, 0, 0, 1, 3'b000, 0,  0, 1, 1, 0, 0, 0, 0, 2, 2, 0, 2, 3));
    tbl.push_back(mk(0, 0, 0, 0, 1, 3'b111, 0,  0, 1, 1, 0, 0, 0, 0, 2, 3, 0, 3, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3'b111, 0,  0, 1, 1, 0, 0, 0, 0, 1, 3, 0, 3, 3));
    tbl.push_back(mk(0, 0, 0, 0, 1, 3'b000, 0,  0, 0, 1, 0, 0, 0, 0, 2, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3'b110, 0,  0, 0, 1, 0, 0, 0, 0, 2, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3'b111, 0,  0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3'b111, 0,  1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3'b000, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2, 8, 1, 0, 3'b000, 0,  0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0, 1, 3'b000, 0,  0, 1, 1, 0, 0, 0, 0, 1, 1, 0, 1, 2));
    tbl.push_back(mk(0, 0, 0, 0, 1, 3'b000, 0,  0, 1, 1, 0, 0, 0, 0, 2, 2, 0, 2, 2));
    tbl.push_back(mk(0, 0, 0, 0, 1, 3'b000, 0,  0, 1, 1, 0, 0, 0, 0, 3, 3, 0, 3, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3'b000, 1,  0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 5, 0, 1, 0, 3'b000, 0,  0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3'b111, 0,  0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3'b000, 0,  0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3'b000, 0,  1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3'b000, 1,  1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1, 0, 3'b000, 0,  0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 3'b000, 0,  0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3'b111, 0,  1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(negedge clk);
      chk($sformatf("vec%0d", i), dut_pk(),
          pk(tbl[i].crdy, tbl[i].val, tbl[i].bsy, tbl[i].dn, tbl[i].ecfg, tbl[i].eab,
             tbl[i].lrst, tbl[i].outs, tbl[i].ot, tbl[i].bt, tbl[i].id, tbl[i].ln));
    end
    drive(mk(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);

    // Full job K=8 NT=3 MT=2, each tile retired 10 cycles after its handshake.
    m_cmd_ready = 1'b1;
    start_job(16'd8, 16'd3, 16'd2);
    issue_cnt = 0; retire_cnt = 0; max_out = 0; done_cyc = -1; last_ret_cyc = -1;
    for (int c = 0; c < 300 && done_cyc < 0; c++) begin
      if (int'(outstanding) > max_out) max_out = int'(outstanding);
      if (done) done_cyc = c;
      if (m_cmd_valid) begin
        chk($sformatf("job_cmd%0d", issue_cnt),
            {32'd0, m_cmd_out_tile, m_cmd_batch_tile, m_cmd_id, m_cmd_len},
            {32'd0, 16'(issue_cnt % 3), 16'(issue_cnt / 3), 8'(issue_cnt), 16'd8});
        retire_at.push_back(c + 10);
        issue_cnt++;
      end
      if (retire_at.size() > 0 && retire_at[0] == c) begin
        void'(retire_at.pop_front());
        set_snoop(1'b1);
        retire_cnt++;
        if (retire_cnt == 6) last_ret_cyc = c;
      end else begin
        set_snoop(1'b0);
      end
      @(negedge clk);
    end
    set_snoop(1'b0);
    chk("job_issue_count", 80'(issue_cnt), 80'd6);
    chk("job_max_outstanding", 80'(max_out), 80'd4);
    chk("job_done_latency", 80'(done_cyc), 80'(last_ret_cyc + 1));

    // Outstanding cap: no retires, NT=8 MT=1.
    start_job(16'd4, 16'd8, 16'd1);
    hs = 0;
    for (int c = 0; c < 12; c++) begin
      if (m_cmd_valid) hs++;
      @(negedge clk);
    end
    chk("cap_issues", 80'(hs), 80'd4);
    chk("cap_valid_low", {79'd0, m_cmd_valid}, 80'd0);
    chk("cap_outstanding", 80'(outstanding), 80'd4);
    set_snoop(1'b1);
    @(negedge clk);
    set_snoop(1'b0);
    hs = 0;
    for (int c = 0; c < 10; c++) begin
      if (m_cmd_valid) hs++;
      @(negedge clk);
    end
    chk("cap_one_more", 80'(hs), 80'd1);
    err_unalligned_data = 1'b1;
    @(negedge clk);
    err_unalligned_data = 1'b0;
    chk("cap_abort", dut_pk(), pk(0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = done;
    end
    chk("cap_abort_done", {79'd0, seen}, 80'd1);
    m_cmd_ready = 1'b0;
    @(negedge clk);

    // Asynchronous reset in the middle of ISSUE.
    m_cmd_ready = 1'b1;
    start_job(16'd7, 16'd2, 16'd1);
    @(negedge clk);
    m_cmd_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("async_reset", dut_pk(), pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    m_cmd_ready = 1'b1;
    start_job(16'd7, 16'd2, 16'd1);
    chk("restart_cmd0", dut_pk(), pk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 7));
    @(negedge clk);
    chk("restart_cmd1", dut_pk(), pk(0, 1, 1, 0, 0, 0, 0, 1, 1, 0, 1, 7));
    @(negedge clk);
    m_cmd_ready = 1'b0;
    chk("restart_drain", dut_pk(), pk(0, 0, 1, 0, 0, 0, 0, 2, 0, 0, 0, 0));
    set_snoop(1'b1);
    @(negedge clk);
    @(negedge clk);
    set_snoop(1'b0);
    chk("restart_done", dut_pk(), pk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/lpa_tile_scheduler.md
Name: lpa_tile_scheduler

Overview:
- Job-level sequencer for the parallelized linear processing array.
- Accepts one matrix-multiply job descriptor and breaks it into tile commands, in batch-tile-major order, for the weight and data stream feeders.
- Snoops the array's result stream to retire tiles, bounds the number of tiles in flight, and signals job completion.
- On array alignment error, aborts the job and resets the array.

Parameters:
- DIM_WIDTH, 16: width of the tile-count and accumulation-length fields.
- ID_WIDTH, 8: width of the command tag, used as the stream tid.
- MAX_OUTSTANDING, 4: maximum number of issued but unretired tiles; must be ≥1.
- RST_CYCLES, 4: number of cycles lpa_rst is held on abort; must be ≥1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active low
- s_cfg_valid  in  1  job descriptor valid
- s_cfg_ready  out  1  descriptor accepted when s_cfg_valid & s_cfg_ready
- s_cfg_len  in  DIM_WIDTH  accumulation length K in beats per tile
- s_cfg_out_tiles  in  DIM_WIDTH  output tiles per batch tile (NT)
- s_cfg_batch_tiles  in  DIM_WIDTH  batch tiles (MT)
- m_cmd_valid  out  1  tile command valid
- m_cmd_ready  in  1  feeder accepts command
- m_cmd_out_tile  out  DIM_WIDTH  output tile index
- m_cmd_batch_tile  out  DIM_WIDTH  batch tile index
- m_cmd_len  out  DIM_WIDTH  K, latched from the descriptor
- m_cmd_id  out  ID_WIDTH  running tile tag
- snoop_tvalid  in  1  lane 0 of the result stream
- snoop_tready  in  1  lane 0 of the result stream
- snoop_tlast  in  1  lane 0 of the result stream
- err_unalligned_data  in  1  array alignment error
- lpa_rst  out  1  active-high reset to the array
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job end
- err_cfg  out  1  one-cycle pulse when a descriptor is rejected
- err_abort  out  1  sticky abort flag; cleared by the next accepted descriptor
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  tiles in flight

Behaviour:
- Reset values (rst_n=0):
  - state=IDLE.
  - All outputs 0, except s_cfg_ready=1.
  - All counters and indices 0.
- All outputs are registered.
- States: IDLE, ISSUE, DRAIN, ABORT.
- IDLE:
  - s_cfg_ready=1.
  - On descriptor handshake, if any of len, out_tiles or batch_tiles is 0:
    - Pulse err_cfg and done on the next cycle.
    - Stay in IDLE and issue no commands.
  - Otherwise:
    - Latch the descriptor and clear err_abort.
    - Set indices to (0,0) and m_cmd_id to 0.
    - Go to ISSUE; busy=1 on the next cycle.
  - s_cfg_ready=0 in every state other than IDLE.
- ISSUE:
  - m_cmd_valid=1 when outstanding<MAX_OUTSTANDING.
  - m_cmd_valid and the payload stay stable until handshake.
  - On handshake:
    - outstanding+1 and m_cmd_id+1 (wraps modulo 2^ID_WIDTH).
    - out_tile+1; at NT-1 it wraps to 0 and batch_tile+1.
  - The handshake of tile (NT-1, MT-1) moves to DRAIN, and m_cmd_valid drops in the same cycle.
  - The first command is presented 1 cycle after descriptor acceptance.
- Retire:
  - One tile retires on each cycle where snoop_tvalid & snoop_tready & snoop_tlast.
  - On retire, outstanding-1.
  - A simultaneous issue and retire leaves outstanding unchanged.
  - A retire while outstanding=0 is ignored; the counter saturates.
- DRAIN:
  - When outstanding reaches 0, pulse done for 1 cycle, clear busy and return to IDLE.
  - done occurs 1 cycle after the final retire.
- ABORT:
  - Entered when err_unalligned_data=1 in ISSUE or DRAIN; err_unalligned_data is ignored in IDLE.
  - On entry: drop m_cmd_valid immediately, even mid-handshake; a command not accepted is lost.
  - Set err_abort and zero outstanding.
  - Hold lpa_rst=1 for exactly RST_CYCLES cycles, then go to IDLE.
  - done pulses on exit; busy stays 1 throughout ABORT.
- Asynchronous reset during any state returns immediately to the reset values.
- Index, tag and counter arithmetic is unsigned modulo width.
- MT×NT is not bounded beyond the DIM_WIDTH fields.

Test Plan:
- Descriptor K=8, NT=3, MT=2, m_cmd_ready=1, snoop retires each tile 10 cycles after issue:
  - 6 commands, (out,batch) order (0,0),(1,0),(2,0),(0,1),(1,1),(2,1), ids 0..5, len 8.
  - outstanding never exceeds 4.
  - done 1 cycle after the 6th retire.
- MAX_OUTSTANDING=4, no retires, NT=8, MT=1: exactly 4 commands issue and m_cmd_valid=0 afterwards. Retire 1 tile → exactly one more command issues.
- Issue and retire in the same cycle with outstanding=2 → outstanding stays 2. Retire with outstanding=0 → stays 0.
- Descriptor with NT=0 → err_cfg=1 and done=1 one cycle later, no m_cmd_valid, s_cfg_ready stays 1.
- err_unalligned_data pulse after 3 commands:
  - m_cmd_valid drops and lpa_rst is held high for 4 cycles.
  - err_abort=1, outstanding=0, done pulses, state returns to IDLE.
  - The next valid descriptor clears err_abort.
- rst_n low mid-ISSUE → all outputs at reset values within the same cycle. Release → a new job runs normally with id restarting at 0.
